// File: rtl/hud_write_queue_pkg.sv
// Shared HUD/framebuffer constants: screen geometry and the default pixel
// address/data widths used by the render stages and the write queue.
package hud_write_queue_pkg;

   localparam int FB_WIDTH  = 640;
   localparam int FB_HEIGHT = 480;
   localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

   // Address width covers every pixel of the framebuffer (307200 < 2**19).
   localparam int HUD_AW = $clog2(FB_PIXELS);
   localparam int HUD_DW = 16;

endpackage

// File: rtl/hud_wq_ram.sv
// Simple dual-port storage for the HUD write queue: registered write port,
// asynchronous read port so the head entry is visible without a read cycle.
module hud_wq_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 35,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [IW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // NOTE: storage has no reset; the queue pointers alone decide which words are valid.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hud_write_queue.sv
// Pixel write queue between the render stage and the VRAM port; show-ahead head.
// Optional macro HUD_WQ_DROP_CNT_EN adds a saturating 16-bit drop_cnt output.
module hud_write_queue
   import hud_write_queue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = HUD_AW,
   parameter int DW    = HUD_DW
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [AW-1:0]             dst_addr,
   input  logic [DW-1:0]             dst_data,
   input  logic                      dst_wr,
   output logic                      dst_stall,
   output logic [AW-1:0]             vram_addr,
   output logic [DW-1:0]             vram_data,
   output logic                      vram_we,
   input  logic                      vram_ready,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      overflow,
   input  logic                      clr_ovf
`ifdef HUD_WQ_DROP_CNT_EN
   ,
   output logic [15:0]               drop_cnt
`endif
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] level_q, level_d;
   logic          stall_q, stall_d;
   logic          ovf_q, ovf_d;
   logic          push, pop, drop;
   logic [AW+DW-1:0] head_word;

   // NOTE: every always_comb output gets its default first so no path can infer a latch.
   always_comb begin
      pop      = (level_q != '0) && vram_ready;
      push     = dst_wr && ((level_q != PW'(DEPTH)) || pop);
      drop     = dst_wr && !push;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + PW'(1);
         2'b01:   level_d = level_q - PW'(1);
         default: level_d = level_q;
      endcase
      // A drop on the clearing edge keeps the flag set.
      if (drop)         ovf_d = 1'b1;
      else if (clr_ovf) ovf_d = 1'b0;
      stall_d = (level_d >= PW'(DEPTH - 2));
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         stall_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         stall_q  <= stall_d;
         ovf_q    <= ovf_d;
      end
   end

   hud_wq_ram #(
      .DEPTH (DEPTH),
      .W     (AW + DW),
      .IW    (IW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q[IW-1:0]),
      .wdata ({dst_addr, dst_data}),
      .raddr (rd_ptr_q[IW-1:0]),
      .rdata (head_word)
   );

   assign {vram_addr, vram_data} = head_word;
   assign vram_we   = (level_q != '0);
   assign level     = level_q;
   assign dst_stall = stall_q;
   assign overflow  = ovf_q;

`ifdef HUD_WQ_DROP_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (drop) begin
         if (clr_ovf)                cnt_d = 16'd1;
         else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end else if (clr_ovf) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign drop_cnt = cnt_q;
`endif

endmodule
